// File: rtl/spi_cmd_rx.sv
// SPI (mode 0, MSB first) command receiver sampled in the system clock domain.
// Assembles fixed-length frames, buffers them in a small FIFO and hands them
// to the consumer over a valid/ready handshake. Flags malformed frames and drops.
module spi_cmd_rx #(
    parameter int unsigned FRAME_BITS  = 16,
    parameter int unsigned FIFO_DEPTH  = 2,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sck_in,
    input  logic                  cs_n_in,
    input  logic                  mosi_in,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [3:0]            cmd_addr,
    output logic [FRAME_BITS-5:0] cmd_data,
    output logic                  frame_err,
    output logic                  overflow,
    output logic                  busy
);

    localparam int unsigned CW = $clog2(FRAME_BITS + 2);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned NW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned WW = $clog2(SYNC_STAGES + 2);

    localparam logic [CW-1:0] CNT_FULL  = CW'(FRAME_BITS);
    localparam logic [CW-1:0] CNT_SAT   = CW'(FRAME_BITS + 1);
    localparam logic [NW-1:0] FIFO_FULL = NW'(FIFO_DEPTH);
    // Synchronizers plus edge-detect register hold real pin history after this many cycles.
    localparam logic [WW-1:0] WARM_DONE = WW'(SYNC_STAGES + 1);

    typedef enum logic {StIdle, StShift} state_e;

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sck_prev;
    logic                   r_cs_prev;
    logic [WW-1:0]          r_warm;

    state_e                 r_state;
    logic [FRAME_BITS-1:0]  r_shift;
    logic [CW-1:0]          r_cnt;
    logic                   r_frame_err;
    logic                   r_overflow;

    logic [FRAME_BITS-1:0]  r_mem [FIFO_DEPTH];
    logic [PW-1:0]          r_wptr;
    logic [PW-1:0]          r_rptr;
    logic [NW-1:0]          r_count;
    logic [FRAME_BITS-1:0]  r_last;

    logic w_sck, w_cs, w_mosi, w_warm;
    logic w_sck_rise, w_cs_fall, w_cs_rise;
    logic w_close, w_good, w_full, w_pop, w_push, w_drop;
    logic [FRAME_BITS-1:0] w_head;

    assign w_sck  = r_sck_sync[SYNC_STAGES-1];
    assign w_cs   = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
    // Edges are masked until the pipeline is refilled, so a CS held low across
    // reset cannot masquerade as a falling edge.
    assign w_warm     = (r_warm == WARM_DONE);
    assign w_sck_rise = w_warm & w_sck & ~r_sck_prev;
    assign w_cs_fall  = w_warm & ~w_cs & r_cs_prev;
    assign w_cs_rise  = w_warm & w_cs & ~r_cs_prev;

    assign w_close = (r_state == StShift) & w_cs_rise;
    assign w_good  = w_close & (r_cnt == CNT_FULL);
    assign w_full  = (r_count == FIFO_FULL);
    assign w_pop   = cmd_valid & cmd_ready;
    assign w_push  = w_good & (~w_full | w_pop);
    assign w_drop  = w_good & w_full & ~w_pop;

    // Pin synchronizers, edge-detect history and post-reset warm-up counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sck_sync  <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sck_prev  <= 1'b0;
            r_cs_prev   <= 1'b1;
            r_warm      <= '0;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck_in};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n_in};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_in};
            r_sck_prev  <= w_sck;
            r_cs_prev   <= w_cs;
            if (!w_warm) begin
                r_warm <= r_warm + 1'b1;
            end
        end
    end

    // Frame FSM: shifts bits while CS is low and raises the close-time pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_cs_fall) begin
                        r_state <= StShift;
                        r_shift <= '0;
                        r_cnt   <= '0;
                    end
                end
                StShift: begin
                    // CS rise wins over a coincident SCK rise.
                    if (w_cs_rise) begin
                        r_state     <= StIdle;
                        r_frame_err <= (r_cnt != CNT_FULL);
                        r_overflow  <= w_drop;
                    end else if (w_sck_rise) begin
                        r_shift <= {r_shift[FRAME_BITS-2:0], w_mosi};
                        if (r_cnt != CNT_SAT) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // FIFO storage; contents need no reset since cmd_valid gates them.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= r_shift;
        end
    end

    // FIFO pointers, occupancy and the held copy of the last valid head.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_last  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (cmd_valid) begin
                r_last <= r_mem[r_rptr];
            end
        end
    end

    assign cmd_valid = (r_count != '0);
    assign w_head    = cmd_valid ? r_mem[r_rptr] : r_last;
    assign cmd_addr  = w_head[FRAME_BITS-1 -: 4];
    assign cmd_data  = w_head[FRAME_BITS-5:0];
    assign frame_err = r_frame_err;
    assign overflow  = r_overflow;
    assign busy      = (r_state == StShift);

endmodule
